// File: rtl/nios_debug_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG host that drives the Nios II debug slave.
package nios_debug_jtag_pkg;

    localparam int DEFAULT_DR_WIDTH = 38;
    localparam int DEFAULT_IR_WIDTH = 2;
    localparam int DEFAULT_CLK_DIV  = 2;

    // Virtual IR encodings understood by the debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACE     = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        RSP  = 3'd6
    } jtag_state_e;

    typedef struct packed {
        logic rti;
        logic udr;
        logic sdr;
        logic cdr;
        logic uir;
    } strobes_t;

    // Virtual-state strobe pattern for a given sequencer state; at most one bit set
    function automatic strobes_t strobesFor(input jtag_state_e state);
        strobes_t s;
        s = '0;
        case (state)
            UIR:     s.uir = 1'b1;
            CDR:     s.cdr = 1'b1;
            SDR:     s.sdr = 1'b1;
            UDR:     s.udr = 1'b1;
            RTI:     s.rti = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nios_debug_jtag_tckgen.sv
// Test-clock generator: divides clk into a low phase and a high phase of CLK_DIV cycles each,
// and flags the clk edges that begin each phase so the sequencer can act on them.
module nios_debug_jtag_tckgen
    import nios_debug_jtag_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    output logic o_tck,
    output logic o_phaseLStart,
    output logic o_phaseHStart
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_div;
    logic       r_tck;
    logic       r_active;
    logic       w_wrap;

    assign w_wrap        = (r_div == LAST);
    // The first edge after run rises opens a low phase; afterwards phases alternate on divider wrap
    assign o_phaseLStart = i_run && (!r_active || (w_wrap && r_tck));
    assign o_phaseHStart = i_run && r_active && w_wrap && !r_tck;
    assign o_tck         = r_tck;

    // Divider and tck level; everything parks at zero whenever the sequencer is not running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_tck    <= 1'b0;
            r_active <= 1'b0;
        end else if (!i_run) begin
            r_div    <= '0;
            r_tck    <= 1'b0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            r_div    <= '0;
            r_tck    <= 1'b0;
            r_active <= 1'b1;
        end else if (w_wrap) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

endmodule

// File: rtl/nios_debug_jtag_host.sv
// Initiator side of the virtual-JTAG link: walks UIR->CDR->SDR->UDR->RTI for each command,
// shifting the command word out on tdi and collecting tdo into the response word.
module nios_debug_jtag_host
    import nios_debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int CLK_DIV  = DEFAULT_CLK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    input  logic                abort,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                busy
);

    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    jtag_state_e         r_state;
    jtag_state_e         w_nextState;
    logic [IR_WIDTH-1:0] r_ir;
    logic [DR_WIDTH-1:0] r_shiftReg;
    logic [DR_WIDTH-1:0] w_shiftNext;
    logic [CNT_W-1:0]    r_bitCnt;
    logic                r_hDone;
    logic                r_abortPend;
    strobes_t            r_strobes;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_irIn;
    logic [IR_WIDTH-1:0] r_rspIrOut;
    logic [DR_WIDTH-1:0] r_rspData;
    logic                w_run;
    logic                w_phaseL;
    logic                w_phaseH;
    logic                w_accept;
    logic                w_abortNow;
    logic                w_lastBit;

    nios_debug_jtag_tckgen #(
        .CLK_DIV(CLK_DIV)
    ) u_tckgen (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_run        (w_run),
        .o_tck        (tck),
        .o_phaseLStart(w_phaseL),
        .o_phaseHStart(w_phaseH)
    );

    assign w_run      = (r_state == UIR) || (r_state == CDR) || (r_state == SDR) ||
                        (r_state == UDR) || (r_state == RTI);
    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_abortNow = abort || r_abortPend;
    assign w_lastBit  = (r_bitCnt == '0);

    // Next content of the shift register: drop the bit just sent, bring the captured tdo in at the top
    always_comb begin
        w_shiftNext = r_shiftReg >> 1;
        w_shiftNext[DR_WIDTH-1] = tdo;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // Next state: TAP states only advance on a low-phase boundary that closes a full period
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_nextState = UIR;
            UIR, CDR, SDR, UDR, RTI: begin
                if (w_phaseL) begin
                    if (r_state == RTI && r_hDone) begin
                        w_nextState = RSP;
                    end else if (w_abortNow) begin
                        w_nextState = IDLE;
                    end else if (r_hDone) begin
                        case (r_state)
                            UIR:     w_nextState = CDR;
                            CDR:     w_nextState = SDR;
                            SDR:     w_nextState = w_lastBit ? UDR : SDR;
                            UDR:     w_nextState = RTI;
                            default: w_nextState = r_state;
                        endcase
                    end
                end
            end
            RSP:     if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: latch commands, shift/capture on phase edges, drive strobes at low-phase starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir        <= '0;
            r_shiftReg  <= '0;
            r_bitCnt    <= '0;
            r_hDone     <= 1'b0;
            r_abortPend <= 1'b0;
            r_strobes   <= '0;
            r_tdi       <= 1'b0;
            r_irIn      <= '0;
            r_rspIrOut  <= '0;
            r_rspData   <= '0;
        end else begin
            if (w_accept) begin
                r_ir        <= cmd_ir;
                r_shiftReg  <= cmd_data;
                r_bitCnt    <= CNT_W'(DR_WIDTH - 1);
                r_hDone     <= 1'b0;
                r_abortPend <= 1'b0;
            end
            if (w_run && abort) begin
                r_abortPend <= 1'b1;
            end
            if (w_phaseH) begin
                r_hDone <= 1'b1;
                if (r_state == UIR) r_rspIrOut <= ir_out;
                if (r_state == SDR) r_shiftReg <= w_shiftNext;
            end
            if (w_phaseL) begin
                r_hDone   <= 1'b0;
                r_strobes <= strobesFor(w_nextState);
                r_tdi     <= (w_nextState == SDR) ? r_shiftReg[0] : 1'b0;
                if (w_nextState == UIR) r_irIn <= r_ir;
                if (r_state == SDR && r_hDone && !w_lastBit) r_bitCnt <= r_bitCnt - 1'b1;
                if (w_nextState == RSP) r_rspData <= r_shiftReg;
                if (w_nextState == IDLE || w_nextState == RSP) r_abortPend <= 1'b0;
            end
        end
    end

    assign cmd_ready      = reset_n && (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign rsp_valid      = (r_state == RSP);
    assign rsp_data       = r_rspData;
    assign rsp_ir_out     = r_rspIrOut;
    assign tdi            = r_tdi;
    assign ir_in          = r_irIn;
    assign vs_uir         = r_strobes.uir;
    assign vs_cdr         = r_strobes.cdr;
    assign vs_sdr         = r_strobes.sdr;
    assign vs_udr         = r_strobes.udr;
    assign jtag_state_rti = r_strobes.rti;

endmodule
